rabbit_ftw_receiver: RTL and testbench
======================================

// Module: rabbit_ftw_receiver
// PURPOSE
//  Serial front end for the Rabbit link. It receives 32-bit DDS frequency tuning words (FTW),
//  MSB first, on a 3-wire bus: SCLK, SDATA, CS_N. Each complete frame is range-checked and
//  clamped against a high limit.
//  Drives a stable registered FTW into the downstream 8-digit hex display converter and DDS
//  load logic. ftw_out changes only on an accepted frame.
// PARAMETERS
//  FTW_WIDTH  32             bits per frame and width of ftw_out
//  FTW_MAX    32'h6666_6666  high limit; an accepted word above this is clamped to it
//  RESET_FTW  32'h0000_0000  value of ftw_out after reset
// PORTS
//  clk          in   1          system clock (50 MHz)
//  reset        in   1          synchronous, active-high reset
//  rabbit_sclk  in   1          async serial clock; data sampled on its rising edge
//  rabbit_sdata in   1          async serial data, MSB first
//  rabbit_cs_n  in   1          async frame enable, active low
//  ftw_out      out  FTW_WIDTH  last accepted (clamped) FTW
//  ftw_valid    out  1          1-cycle pulse when ftw_out is updated
//  limit_hit    out  1          1 = last accepted frame was clamped
//  frame_err    out  1          1-cycle pulse when a frame is rejected (bit count != FTW_WIDTH)
//  frame_count  out  8          accepted-frame counter, wraps 255->0
//  busy         out  1          1 while FSM is not IDLE
// BEHAVIOUR
//  - Reset values: ftw_out=RESET_FTW; ftw_valid, limit_hit, frame_err, busy = 0; frame_count=0.
//    FSM=IDLE, shift reg=0, bit_cnt=0. Reset wins over every other event in the same cycle.
//  - Synchronisers: each Rabbit input passes through a 2-FF synchroniser, then a 3rd FF for
//    edge detection. Edges are judged on synced values only.
//  - SCLK constraint: each SCLK high and low phase lasts >= 3 clk. Faster SCLK is unsupported.
//  - FSM states:
//      IDLE   -> SHIFT on a CS_N falling edge; clears shift reg and bit_cnt.
//      SHIFT  -> on each SCLK rising edge: shift = {shift[W-2:0], sdata};
//                bit_cnt++ saturating at FTW_WIDTH+1.
//                On a CS_N rising edge -> CHECK.
//      CHECK  -> if bit_cnt == FTW_WIDTH: register clamp result -> UPDATE;
//                otherwise pulse frame_err -> IDLE.
//      UPDATE -> load ftw_out, pulse ftw_valid, update limit_hit, frame_count++ -> IDLE.
//  - Clamp rule: ftw_out = (shift > FTW_MAX) ? FTW_MAX : shift. Unsigned compare.
//    limit_hit = (shift > FTW_MAX). A word equal to FTW_MAX is not clamped.
//  - Latency: ftw_valid is high in the cycle after the 4th clk rising edge that follows a
//    rabbit_cs_n rise meeting setup to edge 1. frame_err follows at edge 3.
//  - Simultaneous events: an SCLK rise detected in the same cycle as a CS_N rise is ignored.
//    A CS_N fall while in CHECK or UPDATE is ignored; the next frame needs a fresh fall in IDLE.
//  - Bit count: 0 bits or >FTW_WIDTH bits (saturated) give frame_err.
//    A rejected frame leaves ftw_out, limit_hit and frame_count unchanged.
//  - Reset mid-frame: the partial frame is discarded. If CS_N is still low after reset
//    releases, the FSM stays IDLE until CS_N goes high and falls again.
//  - ftw_valid and frame_err are never high in the same cycle.
// TESTING
//  1 Send 0x1234_5678 -> ftw_out=0x12345678, ftw_valid one cycle 4 clk after CS_N rise,
//    limit_hit=0, frame_count=1.
//  2 Send 0xFFFF_FFFF -> ftw_out=0x66666666, limit_hit=1.
//    Then send 0x6666_6666 -> ftw_out=0x66666666, limit_hit=0.
//  3 Send 31 bits, then 33 bits -> two frame_err pulses, no ftw_valid,
//    ftw_out and frame_count unchanged.
//  4 Assert reset after 16 bits, release with CS_N low, clock 16 more bits, raise CS_N
//    -> no frame_err, no ftw_valid, ftw_out=0.
//  5 Send 256 valid frames -> frame_count wraps to 0; ftw_out equals the last word.
//  6 SCLK at the minimum 3/3 clk phases with random data -> every word received bit-exact.

Source files
------------

// File: rtl/rabbit_ftw_receiver.sv
// Rabbit link serial receiver: synchronises the 3-wire bus, assembles MSB-first
// tuning words, validates the bit count and clamps accepted words to FTW_MAX.
module rabbit_ftw_receiver #(
    parameter int                    FTW_WIDTH = 32,
    parameter logic [FTW_WIDTH-1:0]  FTW_MAX   = 32'h6666_6666,
    parameter logic [FTW_WIDTH-1:0]  RESET_FTW = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rabbit_sclk,
    input  logic                 rabbit_sdata,
    input  logic                 rabbit_cs_n,
    output logic [FTW_WIDTH-1:0] ftw_out,
    output logic                 ftw_valid,
    output logic                 limit_hit,
    output logic                 frame_err,
    output logic [7:0]           frame_count,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FTW_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FTW_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FTW_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [2:0]           cs_sync_q, cs_sync_d;
    logic [1:0]           sdata_sync_q, sdata_sync_d;
    logic [FTW_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FTW_WIDTH-1:0] ftw_q, ftw_d;
    logic                 valid_q, valid_d;
    logic                 hit_q, hit_d;
    logic                 err_q, err_d;
    logic [7:0]           count_q, count_d;
    logic                 busy_q, busy_d;

    logic sclk_rise_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic sdata_s;
    logic over_max_s;

    // Synchroniser shift paths; the third stage of sclk/cs exists only for edge detection.
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], rabbit_sclk};
        cs_sync_d    = {cs_sync_q[1:0], rabbit_cs_n};
        sdata_sync_d = {sdata_sync_q[0], rabbit_sdata};
    end

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
    assign sdata_s     = sdata_sync_q[1];
    assign over_max_s  = (shift_q > FTW_MAX);

    // Frame FSM: next state, shift/count datapath and registered output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ftw_d     = ftw_q;
        valid_d   = 1'b0;
        hit_d     = hit_q;
        err_d     = 1'b0;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = ST_SHIFT;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A clock edge coincident with the frame end is dropped, so the count is final here.
                if (cs_rise_s) begin
                    state_d = ST_CHECK;
                    err_d   = (bit_cnt_q != CNT_FULL);
                end else if (sclk_rise_s) begin
                    shift_d = {shift_q[FTW_WIDTH-2:0], sdata_s};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (bit_cnt_q == CNT_FULL) begin
                    state_d = ST_UPDATE;
                    ftw_d   = over_max_s ? FTW_MAX : shift_q;
                    hit_d   = over_max_s;
                    valid_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b000;
            sdata_sync_q <= 2'b00;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ftw_q        <= RESET_FTW;
            valid_q      <= 1'b0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            sdata_sync_q <= sdata_sync_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ftw_q        <= ftw_d;
            valid_q      <= valid_d;
            hit_q        <= hit_d;
            err_q        <= err_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
        end
    end

    assign ftw_out     = ftw_q;
    assign ftw_valid   = valid_q;
    assign limit_hit   = hit_q;
    assign frame_err   = err_q;
    assign frame_count = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rabbit_ftw_receiver.sv
// Randomised self-checking bench for rabbit_ftw_receiver against a frame-level
// reference model (bit count, clamp, counter wrap, pulse timing).
module tb_rabbit_ftw_receiver;

    localparam logic [31:0] FTW_MAX = 32'h6666_6666;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rabbit_sclk = 1'b0;
    logic        rabbit_sdata = 1'b0;
    logic        rabbit_cs_n = 1'b1;
    logic [31:0] ftw_out;
    logic        ftw_valid;
    logic        limit_hit;
    logic        frame_err;
    logic [7:0]  frame_count;
    logic        busy;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] exp_ftw;
    logic        exp_hit;
    logic [7:0]  exp_count;

    rabbit_ftw_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .rabbit_sclk  (rabbit_sclk),
        .rabbit_sdata (rabbit_sdata),
        .rabbit_cs_n  (rabbit_cs_n),
        .ftw_out      (ftw_out),
        .ftw_valid    (ftw_valid),
        .limit_hit    (limit_hit),
        .frame_err    (frame_err),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, " ftw_out"}, ftw_out, exp_ftw);
        check_eq({tag, " limit_hit"}, {31'd0, limit_hit}, {31'd0, exp_hit});
        check_eq({tag, " frame_count"}, {24'd0, frame_count}, {24'd0, exp_count});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_ftw   = 32'h0;
        exp_hit   = 1'b0;
        exp_count = 8'd0;
    endtask

    // Shift out the low nbits of data, MSB first, with ph clk per SCLK phase.
    task automatic drive_bits(input logic [63:0] data, input int nbits, input int ph);
        for (int i = nbits - 1; i >= 0; i--) begin
            rabbit_sdata = data[i];
            repeat (ph) @(negedge clk);
            rabbit_sclk = 1'b1;
            repeat (ph) @(negedge clk);
            rabbit_sclk = 1'b0;
        end
    endtask

    // After CS_N rises: valid expected only after the 4th edge, err only after the 3rd.
    task automatic watch_end(input string tag, input bit accepted, input bit active);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check_eq({tag, " ftw_valid"}, {31'd0, ftw_valid}, {31'd0, (active && accepted && k == 4)});
            check_eq({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, (active && !accepted && k == 3)});
        end
        check_eq({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send_frame(input string tag, input logic [63:0] data, input int nbits, input int ph);
        bit accepted;
        @(negedge clk);
        rabbit_cs_n = 1'b0;
        repeat (ph) @(negedge clk);
        drive_bits(data, nbits, ph);
        repeat (ph) @(negedge clk);
        check_eq({tag, " busy_frame"}, {31'd0, busy}, 32'd1);
        rabbit_cs_n = 1'b1;
        accepted = (nbits == 32);
        if (accepted) begin
            exp_hit   = (data[31:0] > FTW_MAX);
            exp_ftw   = exp_hit ? FTW_MAX : data[31:0];
            exp_count = exp_count + 8'd1;
        end
        watch_end(tag, accepted, 1'b1);
        check_state(tag);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [63:0] w;
        int nb;
        int lens [5];
        lens = '{0, 31, 32, 33, 40};
        exp_ftw   = 32'h0;
        exp_hit   = 1'b0;
        exp_count = 8'd0;

        do_reset();
        repeat (4) @(negedge clk);
        check_state("reset");
        check_eq("reset ftw_valid", {31'd0, ftw_valid}, 32'd0);
        check_eq("reset frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("reset busy", {31'd0, busy}, 32'd0);

        send_frame("basic", 64'h1234_5678, 32, 4);
        send_frame("clamp", 64'hFFFF_FFFF, 32, 3);
        send_frame("at_max", 64'h6666_6666, 32, 5);
        send_frame("max_plus1", 64'h6666_6667, 32, 3);
        send_frame("short31", 64'h7ABC_DEF1, 31, 3);
        send_frame("long33", 64'h1_2345_6789, 33, 4);
        send_frame("empty", 64'h0, 0, 3);

        // Reset in the middle of a frame, CS_N kept low across the release.
        @(negedge clk);
        rabbit_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        drive_bits(64'hA5A5, 16, 3);
        do_reset();
        check_eq("rst_mid busy", {31'd0, busy}, 32'd0);
        drive_bits(64'h5A5A, 16, 3);
        repeat (3) @(negedge clk);
        check_eq("rst_mid busy2", {31'd0, busy}, 32'd0);
        rabbit_cs_n = 1'b1;
        watch_end("rst_mid", 1'b0, 1'b0);
        check_state("rst_mid");
        repeat (2) @(negedge clk);

        // 256 random words at minimum SCLK phases: counter wraps back to 0.
        for (int f = 0; f < 256; f++) begin
            w = {32'd0, $urandom()};
            send_frame("wrap", w, 32, 3);
        end
        check_eq("wrap count0", {24'd0, frame_count}, 32'd0);

        // Random lengths and phase widths.
        for (int f = 0; f < 20; f++) begin
            w  = {$urandom(), $urandom()};
            nb = lens[$urandom_range(0, 4)];
            send_frame("rand", w, nb, $urandom_range(3, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
